dmem_arbiter: RTL and testbench
===============================

// Module: dmem_arbiter
// PURPOSE
//  Shares the single-port DMEM between two requesters: m0 (CPU load/store unit) and m1 (debug/DMA loader).
//  Round-robin arbitration, req/gnt handshake, registered DMEM drive, one completion pulse per access.
//  Sits between the requesters and the DMEM port set MemRead/MemWrite/addr/WriteData/ReadData.
//  DMEM read is combinational and its write commits on the clk rising edge.
// PARAMETERS
//  ADDR_W  32   byte-address width of requester and DMEM ports
//  DATA_W  32   data word width
//  DEPTH   256  DMEM depth in words; word index = addr[9:2] at default
// PORTS
//  clk             in   1       system clock, rising edge
//  rst             in   1       asynchronous reset, active-high
//  mN_req          in   1       N=0,1: access request; held with its fields stable until mN_gnt
//  mN_we           in   1       1=write, 0=read
//  mN_addr         in   ADDR_W  byte address; bits [1:0] ignored
//  mN_wdata        in   DATA_W  write data
//  mN_gnt          out  1       request accepted this cycle (combinational)
//  mN_done         out  1       one-cycle completion pulse (read or write)
//  mN_rdata        out  DATA_W  read data; valid while mN_done=1 on a read
//  mN_err          out  1       range error; valid while mN_done=1
//  dmem_MemRead    out  1       to DMEM
//  dmem_MemWrite   out  1       to DMEM
//  dmem_addr       out  ADDR_W  to DMEM: {mN_addr[ADDR_W-1:2],2'b00}
//  dmem_WriteData  out  DATA_W  to DMEM
//  dmem_ReadData   in   DATA_W  from DMEM, combinational
// BEHAVIOUR
//  Reset: state=IDLE, last=1 (m0 wins first tie). All outputs 0: gnt, done, err, rdata, dmem_* drive.
//  FSM IDLE -> ACCESS -> RESP.
//   - A grant is possible in IDLE and in RESP.
//   - From RESP: to ACCESS if a grant is issued, otherwise to IDLE.
//  Grant: in IDLE/RESP, mN_gnt = pick(m0_req,m1_req,last). The accepted req/we/addr/wdata/owner are
//   registered at that edge. last := owner. No grant is issued while in ACCESS.
//  Round-robin: if only one req, that requester wins. If both, the requester != last wins.
//  ACCESS (1 cycle): dmem_* are driven from registers.
//   - Write: MemWrite=1; DMEM commits at the closing edge.
//   - Read: MemRead=1; dmem_ReadData is captured into rdata at the closing edge.
//  RESP (1 cycle): owner's mN_done=1, plus mN_rdata (reads) and mN_err. The other mN_done stays 0.
//   - rdata holds its last value after RESP. Writes leave rdata unchanged.
//  Latency: gnt edge -> done = 2 cycles. Sustained throughput = 1 access per 2 cycles (back-to-back via RESP).
//  Both req held continuously: grants alternate m0,m1,m0,...; no starvation.
//  Requester deasserts req before gnt: legal, no access occurs.
//  Reset asserted mid-ACCESS: outputs clear immediately; DMEM commit of the in-flight write is not
//   guaranteed; no done is issued.
//  Reset asserted mid-RESP: done drops immediately.
//  Requester must not re-request before its done. A req seen in RESP from the current owner is arbitrated normally.
// CONFIGURATION
//  DMEM_ARB_RANGE_CHK_EN defined:
//   - word index >= DEPTH or addr[ADDR_W-1:2+clog2(DEPTH)] != 0 -> ACCESS drives no MemRead/MemWrite,
//     and RESP gives done=1, err=1, rdata unchanged.
//  Undefined: err tied 0; upper address bits pass through unchecked (DMEM aliases).
// STRUCTURE
//  dmem_arb_pkg: state enum {IDLE,ACCESS,RESP}; owner_t (1 bit, M0/M1); DEPTH_DEFAULT=256;
//   localparam IDX_W=clog2(DEPTH).
//  Sub-module rr_arbiter2: pure combinational 2-way pick (req[1:0], last -> gnt[1:0], owner).
//  Top holds the FSM, request registers, rdata register and output muxing.
// TESTING
//  1 m0 write 0x08=0xABCD1234, then m0 read 0x08 -> gnt cycle 0; MemWrite=1 cycle 1; done cycle 2;
//    read done shows rdata=0xABCD1234.
//  2 m0,m1 both req held from reset, reads of 0x00/0x04 -> grants m0,m1,m0,m1 spaced 2 cycles;
//    each done carries the correct word.
//  3 m1 writes 0x10=0x5A5A5A5A, m0 reads 0x10 in same cycle -> m0 granted first, reads old value;
//    next m0 read returns 0x5A5A5A5A.
//  4 rst pulsed during ACCESS of an m0 write -> MemWrite and done drop asynchronously; after release state=IDLE,
//    next tie goes to m0.
//  5 DMEM_ARB_RANGE_CHK_EN, m1 read 0x400 -> no MemRead, done=1, err=1;
//    without the macro -> MemRead=1, err=0, data of word 0 (alias).

Source files
------------

// File: rtl/dmem_arb_pkg.sv
// Shared types and constants for the DMEM arbiter.
//   state_t : arbiter FSM states (idle, DMEM access cycle, response cycle)
//   owner_t : which requester owns the current access
package dmem_arb_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StAccess,
    StResp
  } state_t;

  typedef enum logic {
    OwnerM0 = 1'b0,
    OwnerM1 = 1'b1
  } owner_t;

  localparam int unsigned DEPTH_DEFAULT = 256;
  localparam int unsigned IDX_W         = $clog2(DEPTH_DEFAULT);

endpackage

// File: rtl/rr_arbiter2.sv
// Two-way round-robin pick, purely combinational.
//   req   : request vector {m1, m0}
//   last  : owner of the most recent grant
//   gnt   : one-hot grant vector (all zero when nobody requests)
//   owner : index of the winner (M0 when nobody requests)
module rr_arbiter2
  import dmem_arb_pkg::*;
(
  input  logic [1:0] req,
  input  owner_t     last,
  output logic [1:0] gnt,
  output owner_t     owner
);

  always_comb begin
    owner = OwnerM0;
    case (req)
      2'b01:   owner = OwnerM0;
      2'b10:   owner = OwnerM1;
      // Tie: whoever did not win last time.
      2'b11:   owner = (last == OwnerM0) ? OwnerM1 : OwnerM0;
      default: owner = OwnerM0;
    endcase
    gnt = 2'b00;
    if (|req) begin
      gnt = (owner == OwnerM1) ? 2'b10 : 2'b01;
    end
  end

endmodule

// File: rtl/dmem_arbiter.sv
// Shares a single-port DMEM between m0 (load/store unit) and m1 (debug/DMA loader).
// Round-robin req/gnt handshake; one access takes IDLE/RESP -> ACCESS -> RESP, so
// done arrives two cycles after the grant edge and back-to-back accesses run at
// one per two cycles.
// Ports:
//   clk, rst                  clock, asynchronous active-high reset
//   mN_req/we/addr/wdata      request fields, held stable until mN_gnt
//   mN_gnt                    combinational accept
//   mN_done/rdata/err         one-cycle completion pulse with read data and range error
//   dmem_*                    registered drive to DMEM; dmem_ReadData is combinational
// Build option: define DMEM_ARB_RANGE_CHK_EN to reject word indices >= DEPTH with err=1
// and no DMEM strobe; otherwise upper address bits pass through and alias.
module dmem_arbiter
  import dmem_arb_pkg::*;
#(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 32,
  parameter int unsigned DEPTH  = DEPTH_DEFAULT
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              m0_req,
  input  logic              m0_we,
  input  logic [ADDR_W-1:0] m0_addr,
  input  logic [DATA_W-1:0] m0_wdata,
  output logic              m0_gnt,
  output logic              m0_done,
  output logic [DATA_W-1:0] m0_rdata,
  output logic              m0_err,
  input  logic              m1_req,
  input  logic              m1_we,
  input  logic [ADDR_W-1:0] m1_addr,
  input  logic [DATA_W-1:0] m1_wdata,
  output logic              m1_gnt,
  output logic              m1_done,
  output logic [DATA_W-1:0] m1_rdata,
  output logic              m1_err,
  output logic              dmem_MemRead,
  output logic              dmem_MemWrite,
  output logic [ADDR_W-1:0] dmem_addr,
  output logic [DATA_W-1:0] dmem_WriteData,
  input  logic [DATA_W-1:0] dmem_ReadData
);

  state_t            state_q;
  owner_t            last_q, owner_q;
  logic              mem_read_q, mem_write_q, range_err_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q, rdata_q;
  logic [1:0]        done_q;
  logic              err_q;

  logic [1:0]        arb_gnt;
  owner_t            arb_owner;
  logic              grant_ok;
  logic              sel_we, sel_in_range;
  logic [ADDR_W-3:0] sel_word;
  logic [DATA_W-1:0] sel_wdata;
  logic              unused_addr_lsbs;

  rr_arbiter2 u_rr (
    .req   ({m1_req, m0_req}),
    .last  (last_q),
    .gnt   (arb_gnt),
    .owner (arb_owner)
  );

  // Byte offset within a word is ignored.
  assign unused_addr_lsbs = ^{m0_addr[1:0], m1_addr[1:0]};

  // No grant while the port is busy or while reset holds the block.
  assign grant_ok = (state_q != StAccess) && !rst;

  assign sel_we    = (arb_owner == OwnerM1) ? m1_we : m0_we;
  assign sel_word  = (arb_owner == OwnerM1) ? m1_addr[ADDR_W-1:2] : m0_addr[ADDR_W-1:2];
  assign sel_wdata = (arb_owner == OwnerM1) ? m1_wdata : m0_wdata;

`ifdef DMEM_ARB_RANGE_CHK_EN
  localparam logic [ADDR_W-3:0] WordLimit = (ADDR_W-2)'(DEPTH);
  assign sel_in_range = (sel_word < WordLimit);
`else
  assign sel_in_range = 1'b1;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= StIdle;
      last_q      <= OwnerM1;
      owner_q     <= OwnerM0;
      mem_read_q  <= 1'b0;
      mem_write_q <= 1'b0;
      range_err_q <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      rdata_q     <= '0;
      done_q      <= 2'b00;
      err_q       <= 1'b0;
    end else begin
      mem_read_q  <= 1'b0;
      mem_write_q <= 1'b0;
      done_q      <= 2'b00;
      err_q       <= 1'b0;
      case (state_q)
        StIdle, StResp: begin
          if (grant_ok && (|arb_gnt)) begin
            state_q     <= StAccess;
            owner_q     <= arb_owner;
            last_q      <= arb_owner;
            mem_read_q  <= !sel_we && sel_in_range;
            mem_write_q <= sel_we && sel_in_range;
            range_err_q <= !sel_in_range;
            addr_q      <= {sel_word, 2'b00};
            wdata_q     <= sel_wdata;
          end else begin
            state_q <= StIdle;
          end
        end
        StAccess: begin
          state_q <= StResp;
          done_q  <= (owner_q == OwnerM1) ? 2'b10 : 2'b01;
          err_q   <= range_err_q;
          if (mem_read_q) begin
            rdata_q <= dmem_ReadData;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign m0_gnt         = grant_ok && arb_gnt[0];
  assign m1_gnt         = grant_ok && arb_gnt[1];
  assign m0_done        = done_q[0];
  assign m1_done        = done_q[1];
  assign m0_err         = err_q && done_q[0];
  assign m1_err         = err_q && done_q[1];
  assign m0_rdata       = rdata_q;
  assign m1_rdata       = rdata_q;
  assign dmem_MemRead   = mem_read_q;
  assign dmem_MemWrite  = mem_write_q;
  assign dmem_addr      = addr_q;
  assign dmem_WriteData = wdata_q;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Self-checking bench for dmem_arbiter: per-cycle vector table plus hand-written
// reset-during-ACCESS / reset-during-RESP sequences. Contains a small DMEM model
// preloaded with word k = 0x1000_0000 + k.
module tb_dmem_arbiter;

`ifdef DMEM_ARB_RANGE_CHK_EN
  localparam bit RC = 1'b1;
`else
  localparam bit RC = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        m0_req, m0_we, m1_req, m1_we;
  logic [31:0] m0_addr, m0_wdata, m1_addr, m1_wdata;
  logic        m0_gnt, m0_done, m0_err, m1_gnt, m1_done, m1_err;
  logic [31:0] m0_rdata, m1_rdata;
  logic        dmem_MemRead, dmem_MemWrite;
  logic [31:0] dmem_addr, dmem_WriteData, dmem_ReadData;

  always #5 clk = ~clk;

  dmem_arbiter dut (
    .clk            (clk),
    .rst            (rst),
    .m0_req         (m0_req),
    .m0_we          (m0_we),
    .m0_addr        (m0_addr),
    .m0_wdata       (m0_wdata),
    .m0_gnt         (m0_gnt),
    .m0_done        (m0_done),
    .m0_rdata       (m0_rdata),
    .m0_err         (m0_err),
    .m1_req         (m1_req),
    .m1_we          (m1_we),
    .m1_addr        (m1_addr),
    .m1_wdata       (m1_wdata),
    .m1_gnt         (m1_gnt),
    .m1_done        (m1_done),
    .m1_rdata       (m1_rdata),
    .m1_err         (m1_err),
    .dmem_MemRead   (dmem_MemRead),
    .dmem_MemWrite  (dmem_MemWrite),
    .dmem_addr      (dmem_addr),
    .dmem_WriteData (dmem_WriteData),
    .dmem_ReadData  (dmem_ReadData)
  );

  // DMEM model: combinational read, write on rising edge, 256 words (aliases above).
  logic [31:0] mem [256];
  bit          mem_ready = 1'b0;
  always @(posedge clk) begin
    if (!mem_ready) begin
      for (int k = 0; k < 256; k++) mem[k] <= 32'h1000_0000 + 32'(k);
      mem_ready <= 1'b1;
    end else if (dmem_MemWrite) begin
      mem[dmem_addr[9:2]] <= dmem_WriteData;
    end
  end
  assign dmem_ReadData = mem[dmem_addr[9:2]];

  typedef struct {
    logic        rst;
    logic        r0, w0;
    logic [31:0] a0, d0;
    logic        r1, w1;
    logic [31:0] a1, d1;
    logic        g0, g1, mr, mw, dn0, dn1, er, chk_rd;
    logic [31:0] rd, ea, ewd;
  } vec_t;

  vec_t vq[$];
  int   n_checks = 0;
  int   n_errors = 0;

  task automatic add(input logic rs, input logic r0, input logic w0, input logic [31:0] a0,
                     input logic [31:0] d0, input logic r1, input logic w1,
                     input logic [31:0] a1, input logic [31:0] d1, input logic g0,
                     input logic g1, input logic mr, input logic mw, input logic dn0,
                     input logic dn1, input logic er, input logic chk, input logic [31:0] rd,
                     input logic [31:0] ea, input logic [31:0] ewd);
    vec_t v;
    v.rst = rs; v.r0 = r0; v.w0 = w0; v.a0 = a0; v.d0 = d0;
    v.r1 = r1; v.w1 = w1; v.a1 = a1; v.d1 = d1;
    v.g0 = g0; v.g1 = g1; v.mr = mr; v.mw = mw; v.dn0 = dn0; v.dn1 = dn1; v.er = er;
    v.chk_rd = chk; v.rd = rd; v.ea = ea; v.ewd = ewd;
    vq.push_back(v);
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drive(input logic r0, input logic w0, input logic [31:0] a0,
                       input logic [31:0] d0, input logic r1, input logic w1,
                       input logic [31:0] a1, input logic [31:0] d1);
    m0_req = r0; m0_we = w0; m0_addr = a0; m0_wdata = d0;
    m1_req = r1; m1_we = w1; m1_addr = a1; m1_wdata = d1;
  endtask

  initial begin
    rst = 1'b1;
    drive(0, 0, 0, 0, 0, 0, 0, 0);

    // Test 1: m0 write 0x08, then m0 read 0x08.
    add(1, 0,0,0,0,                  0,0,0,0,               0,0, 0,0, 0,0, 0, 0,0,0,0);
    add(0, 1,1,'h08,'hABCD1234,      0,0,0,0,               1,0, 0,0, 0,0, 0, 0,0,0,0);
    add(0, 0,0,0,0,                  0,0,0,0,               0,0, 0,1, 0,0, 0, 0,0,'h08,'hABCD1234);
    add(0, 1,0,'h08,0,               0,0,0,0,               1,0, 0,0, 1,0, 0, 0,0,0,0);
    add(0, 0,0,0,0,                  0,0,0,0,               0,0, 1,0, 0,0, 0, 0,0,'h08,0);
    add(0, 0,0,0,0,                  0,0,0,0,               0,0, 0,0, 1,0, 0, 1,'hABCD1234,0,0);
    add(0, 0,0,0,0,                  0,0,0,0,               0,0, 0,0, 0,0, 0, 0,0,0,0);
    // Test 2: both held from reset, reads of 0x00 / 0x04 alternate m0,m1,m0,m1.
    add(1, 0,0,0,0,                  0,0,0,0,               0,0, 0,0, 0,0, 0, 0,0,0,0);
    add(0, 1,0,'h00,0,               1,0,'h04,0,            1,0, 0,0, 0,0, 0, 0,0,0,0);
    add(0, 1,0,'h00,0,               1,0,'h04,0,            0,0, 1,0, 0,0, 0, 0,0,'h00,0);
    add(0, 1,0,'h00,0,               1,0,'h04,0,            0,1, 0,0, 1,0, 0, 1,'h10000000,0,0);
    add(0, 1,0,'h00,0,               1,0,'h04,0,            0,0, 1,0, 0,0, 0, 0,0,'h04,0);
    add(0, 1,0,'h00,0,               1,0,'h04,0,            1,0, 0,0, 0,1, 0, 1,'h10000001,0,0);
    add(0, 1,0,'h00,0,               1,0,'h04,0,            0,0, 1,0, 0,0, 0, 0,0,'h00,0);
    add(0, 1,0,'h00,0,               1,0,'h04,0,            0,1, 0,0, 1,0, 0, 1,'h10000000,0,0);
    add(0, 1,0,'h00,0,               1,0,'h04,0,            0,0, 1,0, 0,0, 0, 0,0,'h04,0);
    add(0, 0,0,0,0,                  0,0,0,0,               0,0, 0,0, 0,1, 0, 1,'h10000001,0,0);
    add(0, 0,0,0,0,                  0,0,0,0,               0,0, 0,0, 0,0, 0, 0,0,0,0);
    // Test 3: m1 write 0x10 vs m0 read 0x10 (byte offset ignored); m0 sees old then new.
    add(1, 0,0,0,0,                  0,0,0,0,               0,0, 0,0, 0,0, 0, 0,0,0,0);
    add(0, 1,0,'h13,0,               1,1,'h10,'h5A5A5A5A,   1,0, 0,0, 0,0, 0, 0,0,0,0);
    add(0, 0,0,0,0,                  1,1,'h10,'h5A5A5A5A,   0,0, 1,0, 0,0, 0, 0,0,'h10,0);
    add(0, 1,0,'h12,0,               1,1,'h10,'h5A5A5A5A,   0,1, 0,0, 1,0, 0, 1,'h10000004,0,0);
    add(0, 1,0,'h12,0,               0,0,0,0,               0,0, 0,1, 0,0, 0, 0,0,'h10,'h5A5A5A5A);
    add(0, 1,0,'h12,0,               0,0,0,0,               1,0, 0,0, 0,1, 0, 0,0,0,0);
    add(0, 0,0,0,0,                  0,0,0,0,               0,0, 1,0, 0,0, 0, 0,0,'h10,0);
    add(0, 0,0,0,0,                  0,0,0,0,               0,0, 0,0, 1,0, 0, 1,'h5A5A5A5A,0,0);
    add(0, 0,0,0,0,                  0,0,0,0,               0,0, 0,0, 0,0, 0, 0,0,0,0);
    // Test 5: m1 read 0x400 (out of range / alias), then m0 read of last word 0x3FC.
    add(0, 0,0,0,0,                  1,0,'h400,0,           0,1, 0,0, 0,0, 0, 0,0,0,0);
    add(0, 0,0,0,0,                  0,0,0,0,               0,0, !RC,0, 0,0, 0, 0,0,'h400,0);
    add(0, 0,0,0,0,                  0,0,0,0,               0,0, 0,0, 0,1, RC, 1,
        RC ? 32'h5A5A5A5A : 32'h10000000, 0, 0);
    add(0, 1,0,'h3FC,0,              0,0,0,0,               1,0, 0,0, 0,0, 0, 0,0,0,0);
    add(0, 0,0,0,0,                  0,0,0,0,               0,0, 1,0, 0,0, 0, 0,0,'h3FC,0);
    add(0, 0,0,0,0,                  0,0,0,0,               0,0, 0,0, 1,0, 0, 1,'h100000FF,0,0);
    add(0, 0,0,0,0,                  0,0,0,0,               0,0, 0,0, 0,0, 0, 0,0,0,0);

    @(posedge clk); #1;
    for (int i = 0; i < vq.size(); i++) begin
      vec_t v;
      v = vq[i];
      rst = v.rst;
      drive(v.r0, v.w0, v.a0, v.d0, v.r1, v.w1, v.a1, v.d1);
      @(negedge clk);
      chk($sformatf("row%0d m0_gnt", i), 32'(m0_gnt), 32'(v.g0));
      chk($sformatf("row%0d m1_gnt", i), 32'(m1_gnt), 32'(v.g1));
      chk($sformatf("row%0d MemRead", i), 32'(dmem_MemRead), 32'(v.mr));
      chk($sformatf("row%0d MemWrite", i), 32'(dmem_MemWrite), 32'(v.mw));
      chk($sformatf("row%0d m0_done", i), 32'(m0_done), 32'(v.dn0));
      chk($sformatf("row%0d m1_done", i), 32'(m1_done), 32'(v.dn1));
      chk($sformatf("row%0d m0_err", i), 32'(m0_err), 32'(v.er & v.dn0));
      chk($sformatf("row%0d m1_err", i), 32'(m1_err), 32'(v.er & v.dn1));
      if (v.mr || v.mw) chk($sformatf("row%0d dmem_addr", i), dmem_addr, v.ea);
      if (v.mw) chk($sformatf("row%0d WriteData", i), dmem_WriteData, v.ewd);
      if (v.chk_rd) begin
        if (v.dn1) chk($sformatf("row%0d m1_rdata", i), m1_rdata, v.rd);
        else       chk($sformatf("row%0d m0_rdata", i), m0_rdata, v.rd);
      end
      if (v.rst) begin
        chk($sformatf("row%0d rst m0_rdata", i), m0_rdata, 32'h0);
        chk($sformatf("row%0d rst m1_rdata", i), m1_rdata, 32'h0);
        chk($sformatf("row%0d rst dmem_addr", i), dmem_addr, 32'h0);
      end
      @(posedge clk); #1;
    end

    // Test 4: reset pulsed during ACCESS of an m0 write.
    rst = 1'b0;
    drive(1, 1, 'h20, 'hDEADBEEF, 0, 0, 0, 0);
    @(negedge clk);
    chk("t4 m0_gnt", 32'(m0_gnt), 32'h1);
    @(posedge clk); #1;
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    @(negedge clk);
    chk("t4 MemWrite in ACCESS", 32'(dmem_MemWrite), 32'h1);
    #1 rst = 1'b1;
    #1;
    chk("t4 MemWrite after rst", 32'(dmem_MemWrite), 32'h0);
    chk("t4 m0_done after rst", 32'(m0_done), 32'h0);
    @(posedge clk); #1;
    chk("t4 m0_done held rst", 32'(m0_done), 32'h0);
    @(negedge clk);
    rst = 1'b0;
    drive(1, 0, 'h00, 0, 1, 0, 'h04, 0);
    #1;
    chk("t4 tie m0_gnt", 32'(m0_gnt), 32'h1);
    chk("t4 tie m1_gnt", 32'(m1_gnt), 32'h0);
    @(posedge clk); #1;
    drive(0, 0, 0, 0, 1, 0, 'h04, 0);
    @(posedge clk); #1;
    @(negedge clk);
    chk("t4 RESP m0_done", 32'(m0_done), 32'h1);
    chk("t4 RESP m1_gnt", 32'(m1_gnt), 32'h1);
    // Reset during RESP: done must drop at once.
    #1 rst = 1'b1;
    #1;
    chk("t4 RESP rst m0_done", 32'(m0_done), 32'h0);
    chk("t4 RESP rst m1_gnt", 32'(m1_gnt), 32'h0);
    @(negedge clk);
    rst = 1'b0;
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    repeat (3) @(posedge clk);
    #1;
    chk("t4 idle MemRead", 32'(dmem_MemRead), 32'h0);
    chk("t4 idle m1_done", 32'(m1_done), 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
